// File: rtl/idx_pkg.sv
// Shared opcodes, default sizes and channel numbering for the loop-index counter bank.
package idx_pkg;

  localparam logic [2:0] IDX_OP_NOP   = 3'd0;
  localparam logic [2:0] IDX_OP_WRITE = 3'd1;
  localparam logic [2:0] IDX_OP_INC   = 3'd2;
  localparam logic [2:0] IDX_OP_RESET = 3'd3;
  localparam logic [2:0] IDX_OP_LIMIT = 3'd4;
  localparam logic [2:0] IDX_OP_STEP  = 3'd5;
  localparam logic [2:0] IDX_OP_CLEAR = 3'd6;
  localparam logic [2:0] IDX_OP_RSVD  = 3'd7;

  localparam int IDX_W = 8;
  localparam int IDX_N = 3;

  localparam int IDX_CURR = 0;
  localparam int IDX_COL  = 1;
  localparam int IDX_ROW  = 2;

endpackage

// File: rtl/idx_channel.sv
// One loop-index channel: index and limit registers, limit compare and wrap pulse.
module idx_channel #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_idx,
  input  logic         wr_lim,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] data,
  output logic [W-1:0] idx,
  output logic         at_lim,
  output logic         wrap
);

  logic [W-1:0] idx_q;
  logic [W-1:0] lim_q;

  // >= so an index written past its limit wraps on the next increment
  assign at_lim = (idx_q >= lim_q);
  assign idx    = idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      lim_q <= '1;
      wrap  <= 1'b0;
    end else begin
      wrap <= inc & at_lim;
      if (clr) begin
        idx_q <= '0;
      end else if (wr_idx) begin
        idx_q <= data;
      end else if (inc) begin
        idx_q <= at_lim ? '0 : idx_q + W'(1);
      end
      if (wr_lim) begin
        lim_q <= data;
      end
    end
  end

endmodule

// File: rtl/idx_counter_bank.sv
// Bank of N loop-index channels with odometer-style STEP and read-back mux.
// The STEP opcode and done flag are built only when IDX_STEP_EN is defined.
module idx_counter_bank
  import idx_pkg::*;
#(
  parameter  int W     = IDX_W,
  parameter  int N     = IDX_N,
  localparam int SEL_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op_code,
  input  logic [SEL_W-1:0] op_sel,
  input  logic [W-1:0]     op_data,
  input  logic [SEL_W-1:0] rd_sel,
  output logic [W-1:0]     rd_data,
  output logic [N*W-1:0]   idx_flat,
  output logic [N-1:0]     wrap,
  output logic             done,
  output logic             err
);

  localparam logic [SEL_W:0] N_EXT = (SEL_W+1)'(N);

  logic         sel_ok;
  logic         chan_op;
  logic         step_op;
  logic         clear_op;
  logic         illegal;
  logic [N:0]   carry;
  logic [N-1:0] at_lim;
  logic [N-1:0] wr_idx;
  logic [N-1:0] wr_lim;
  logic [N-1:0] clr;
  logic [N-1:0] inc;
  logic [W-1:0] idx_arr [N];
  logic         done_q;
  logic         err_q;

  assign sel_ok   = ({1'b0, op_sel} < N_EXT);
  assign chan_op  = (op_code == IDX_OP_WRITE) || (op_code == IDX_OP_INC) ||
                    (op_code == IDX_OP_RESET) || (op_code == IDX_OP_LIMIT);
  assign clear_op = op_valid && (op_code == IDX_OP_CLEAR);

`ifdef IDX_STEP_EN
  assign step_op = op_valid && (op_code == IDX_OP_STEP);
  assign illegal = op_valid && ((op_code == IDX_OP_RSVD) || (chan_op && !sel_ok));
`else
  assign step_op = 1'b0;
  assign illegal = op_valid && ((op_code == IDX_OP_RSVD) || (op_code == IDX_OP_STEP) ||
                                (chan_op && !sel_ok));
`endif

  // Carry into channel i: every lower channel sits at or above its limit
  assign carry[0] = 1'b1;

  for (genvar i = 0; i < N; i++) begin : g_chan
    logic hit;
    assign hit         = op_valid && (op_sel == SEL_W'(i));
    assign wr_idx[i]   = hit && (op_code == IDX_OP_WRITE);
    assign wr_lim[i]   = hit && (op_code == IDX_OP_LIMIT);
    assign clr[i]      = (hit && (op_code == IDX_OP_RESET)) || clear_op;
    assign inc[i]      = (hit && (op_code == IDX_OP_INC)) || (step_op && carry[i]);
    assign carry[i+1]  = carry[i] & at_lim[i];
    assign idx_flat[i*W +: W] = idx_arr[i];

    idx_channel #(.W(W)) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .wr_idx (wr_idx[i]),
      .wr_lim (wr_lim[i]),
      .clr    (clr[i]),
      .inc    (inc[i]),
      .data   (op_data),
      .idx    (idx_arr[i]),
      .at_lim (at_lim[i]),
      .wrap   (wrap[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      err_q <= illegal;
      if (clear_op) begin
        done_q <= 1'b0;
      end else if (step_op && carry[N]) begin
        done_q <= 1'b1;
      end
    end
  end

  assign done = done_q;
  assign err  = err_q;

  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N; i++) begin
      if ({1'b0, rd_sel} == (SEL_W+1)'(i)) begin
        rd_data = idx_arr[i];
      end
    end
  end

endmodule

// File: tb/tb_idx_counter_bank.sv
// Directed self-checking bench for idx_counter_bank (W=8, N=3), covering both IDX_STEP_EN builds.
module tb_idx_counter_bank;
  import idx_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        op_valid;
  logic [2:0]  op_code;
  logic [1:0]  op_sel;
  logic [7:0]  op_data;
  logic [1:0]  rd_sel;
  logic [7:0]  rd_data;
  logic [23:0] idx_flat;
  logic [2:0]  wrap;
  logic        done;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  idx_counter_bank #(.W(8), .N(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .op_valid (op_valid),
    .op_code  (op_code),
    .op_sel   (op_sel),
    .op_data  (op_data),
    .rd_sel   (rd_sel),
    .rd_data  (rd_data),
    .idx_flat (idx_flat),
    .wrap     (wrap),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input logic [2:0] code, input logic [1:0] sel, input logic [7:0] data);
    @(negedge clk);
    op_valid = 1'b1;
    op_code  = code;
    op_sel   = sel;
    op_data  = data;
    @(posedge clk);
    #1;
    op_valid = 1'b0;
    op_code  = IDX_OP_NOP;
  endtask

  function automatic logic [23:0] odo(input int c);
    logic [2:0] b;
    b = 3'(c);
    return {7'b0, b[2], 7'b0, b[1], 7'b0, b[0]};
  endfunction

  initial begin
    logic [2:0] prev_b;
    logic [2:0] next_b;
    rst_n = 1'b1; op_valid = 1'b0; op_code = '0; op_sel = '0; op_data = '0; rd_sel = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_idx_flat", 32'(idx_flat), 32'h0);
    check("rst_ctl", {29'b0, wrap}, 32'h0);
    check("rst_done_err", {30'b0, done, err}, 32'h0);
    #20 rst_n = 1'b1;

    do_op(IDX_OP_WRITE, 2'd0, 8'd5);
    check("write_ch0", 32'(idx_flat), 32'h000005);
    check("rd_ch0", 32'(rd_data), 32'h05);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_idx", 32'(idx_flat), 32'h0);
    #1 rst_n = 1'b1;

    // reset limit must be 0xFF
    do_op(IDX_OP_WRITE, 2'd0, 8'hFE);
    do_op(IDX_OP_INC, 2'd0, 8'h00);
    check("lim_rst_fe_inc", {idx_flat[7:0], 5'b0, wrap}, {8'hFF, 8'h00});
    do_op(IDX_OP_INC, 2'd0, 8'h00);
    check("lim_rst_ff_inc", {idx_flat[7:0], 5'b0, wrap}, {8'h00, 8'h01});

    do_op(IDX_OP_LIMIT, 2'd0, 8'd3);
    do_op(IDX_OP_INC, 2'd0, 8'h00);
    check("inc_1", {idx_flat[7:0], 5'b0, wrap}, {8'd1, 8'h00});
    do_op(IDX_OP_INC, 2'd0, 8'h00);
    check("inc_2", {idx_flat[7:0], 5'b0, wrap}, {8'd2, 8'h00});
    do_op(IDX_OP_INC, 2'd0, 8'h00);
    check("inc_3", {idx_flat[7:0], 5'b0, wrap}, {8'd3, 8'h00});
    do_op(IDX_OP_INC, 2'd0, 8'h00);
    check("inc_wrap0", {idx_flat[7:0], 5'b0, wrap}, {8'd0, 8'h01});
    do_op(IDX_OP_INC, 2'd0, 8'h00);
    check("inc_after_wrap", {idx_flat[7:0], 5'b0, wrap}, {8'd1, 8'h00});

    do_op(IDX_OP_LIMIT, 2'd1, 8'd4);
    do_op(IDX_OP_WRITE, 2'd1, 8'd10);
    rd_sel = 2'd1;
    #1;
    check("rd_ch1_above_lim", 32'(rd_data), 32'd10);
    do_op(IDX_OP_INC, 2'd1, 8'h00);
    check("inc_above_lim", {8'b0, idx_flat}, 32'h000001);
    check("wrap_ch1", {29'b0, wrap}, 32'h2);

    do_op(IDX_OP_RESET, 2'd0, 8'h00);
    check("reset_ch0", 32'(idx_flat), 32'h0);

    do_op(IDX_OP_WRITE, 2'd2, 8'h5A);
    do_op(IDX_OP_INC, 2'd3, 8'h00);
    check("bad_sel_idx", 32'(idx_flat), 32'h5A0000);
    check("bad_sel_err", {31'b0, err}, 32'h1);
    do_op(IDX_OP_NOP, 2'd0, 8'h00);
    check("err_one_cycle", {31'b0, err}, 32'h0);
    do_op(IDX_OP_RSVD, 2'd0, 8'h33);
    check("rsvd_idx", 32'(idx_flat), 32'h5A0000);
    check("rsvd_err", {31'b0, err}, 32'h1);
    rd_sel = 2'd3;
    #1;
    check("rd_out_of_range", 32'(rd_data), 32'h0);
    rd_sel = 2'd2;
    #1;
    check("rd_ch2", 32'(rd_data), 32'h5A);

`ifdef IDX_STEP_EN
    do_op(IDX_OP_CLEAR, 2'd0, 8'h00);
    check("clear_all", 32'(idx_flat), 32'h0);
    do_op(IDX_OP_LIMIT, 2'd0, 8'd1);
    do_op(IDX_OP_LIMIT, 2'd1, 8'd1);
    do_op(IDX_OP_LIMIT, 2'd2, 8'd1);
    for (int k = 1; k <= 8; k++) begin
      do_op(IDX_OP_STEP, 2'd0, 8'h00);
      prev_b = 3'(k - 1);
      next_b = 3'(k);
      check($sformatf("step%0d_idx", k), 32'(idx_flat), 32'(odo(k)));
      check($sformatf("step%0d_wrap", k), {29'b0, wrap}, {29'b0, prev_b & ~next_b});
      check($sformatf("step%0d_done", k), {31'b0, done}, (k == 8) ? 32'h1 : 32'h0);
    end
    do_op(IDX_OP_STEP, 2'd0, 8'h00);
    check("step_after_done", {7'b0, done, idx_flat}, {7'b0, 1'b1, 24'h000001});
    do_op(IDX_OP_CLEAR, 2'd0, 8'h00);
    check("clear_done", {7'b0, done, idx_flat}, 32'h0);
`else
    do_op(IDX_OP_STEP, 2'd0, 8'h00);
    check("step_off_idx", 32'(idx_flat), 32'h5A0000);
    check("step_off_err", {31'b0, err}, 32'h1);
    check("step_off_done", {31'b0, done}, 32'h0);
    do_op(IDX_OP_CLEAR, 2'd0, 8'h00);
    check("clear_all", {7'b0, done, idx_flat}, 32'h0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/idx_counter_bank.md
# idx_counter_bank

Parametrised bank of loop-index registers for the matrix datapath, generalising the fixed ROW/COL/CURR counters into N channels of width W. Each channel has its own programmable limit and wraps from the limit back to zero. A nested STEP operation advances all channels as one odometer. The bank is driven by decoded control-unit operations, and any channel can be read back onto the datapath bus through `rd_data`.

## Interface
- `W`, 8: index and limit width in bits.
- `N`, 3: number of channels; channel 0 is innermost (CURR), 1 is COL, 2 is ROW.
- `SEL_W`, max(1, clog2(N)): selector width (derived, not overridden).

- `clk`  in  1  datapath clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `op_valid`  in  1  qualifies `op_code`; when low the cycle is a NOP.
- `op_code`  in  3  operation, encodings below.
- `op_sel`  in  SEL_W  target channel.
- `op_data`  in  W  write data for WRITE and LIMIT.
- `rd_sel`  in  SEL_W  read-back channel select.
- `rd_data`  out  W  combinational `idx[rd_sel]`; reads 0 when `rd_sel >= N`.
- `idx_flat`  out  N*W  all indices, channel i at bits [i*W +: W].
- `wrap`  out  N  one-cycle pulse per channel that wrapped this cycle.
- `done`  out  1  sticky; set when STEP wraps every channel.
- `err`  out  1  one-cycle pulse on an illegal operation.

## Operation
- Opcodes:
  - 0 NOP.
  - 1 WRITE: `idx[sel] = op_data`.
  - 2 INC: increments channel `sel`.
  - 3 RESET: `idx[sel] = 0`.
  - 4 LIMIT: `lim[sel] = op_data`.
  - 5 STEP: nested increment.
  - 6 CLEAR_ALL: all `idx` = 0, `done` = 0.
  - 7 reserved: no state change, `err` pulse.
- INC on channel c:
  - If `idx[c] >= lim[c]`: `idx[c] = 0` and `wrap[c]` pulses.
  - Otherwise `idx[c] = idx[c] + 1`.
  - The compare uses `>=`, so an index written above its limit wraps on its next INC.
- STEP:
  - Channel 0 always gets the INC rule.
  - Channel i > 0 gets the INC rule only if every channel below it is at or above its limit in the same cycle (carry chain).
  - If all N channels wrap, `done` is set.
  - All `wrap` bits for the channels that wrapped pulse together.
- Channel-addressed ops with `op_sel >= N` (WRITE, INC, RESET, LIMIT): no state change, `err` pulses.
- Only one operation per cycle, so there are no simultaneous-write conflicts.
- `done` is cleared only by CLEAR_ALL or reset. Further STEPs while `done` is high continue counting and leave `done` high.
- LIMIT of 0 makes the channel wrap on every INC/STEP. `wrap` pulses each time and the index stays 0.
- Additions are W-bit with no overflow beyond the limit compare. With `lim = 2^W-1` the channel behaves as a free-running modulo-2^W counter.

## Timing
- Reset values:
  - `idx` all 0.
  - `lim` all ones (2^W-1).
  - `wrap` = 0, `done` = 0, `err` = 0.
  - `rd_data` and `idx_flat` therefore read 0.
- Reset asserted mid-operation: all state returns to reset values immediately, independent of `clk`.
- Operation latency is 1 cycle. An op sampled at edge k is visible on `idx_flat`/`rd_data` after edge k.
- `wrap`, `done` and `err` are registered and update at the same edge as the index change.
- `rd_data` is combinational from the registered `idx` and `rd_sel`; it has no added latency.
- There is no handshake or backpressure: every valid op completes in one cycle.

## Configuration
- `IDX_STEP_EN`:
  - Defined: the STEP opcode and carry chain are built, and `done` is set as described.
  - Undefined: opcode 5 is treated as reserved (no state change, `err` pulse), and `done` is tied to 0.

## Structure
- Package `idx_pkg`:
  - Opcode localparams `IDX_OP_NOP` … `IDX_OP_RSVD` (3-bit).
  - Default `IDX_W = 8` and `IDX_N = 3`.
  - Channel-number constants `IDX_CURR = 0`, `IDX_COL = 1`, `IDX_ROW = 2`.
- One sub-module, `idx_channel`, holds one channel:
  - It contains the `idx` and `lim` registers, the `>=` compare and the wrap logic.
  - Its outputs are `at_lim` (feeds the STEP carry chain) and `wrap`.
  - The top generates N instances, plus the opcode decode, selector range check, carry chain, `done`/`err` registers and read mux.

## Test plan
- Reset: hold `rst_n=0` mid-count with `idx0=5` -> all of `idx_flat` reads 0 and `lim` is 0xFF immediately, before any clock edge.
- LIMIT ch0 = 3, then 5× INC ch0 -> `idx0` goes 1,2,3,0,1, and `wrap[0]` pulses only on the 3→0 edge.
- WRITE ch1 = 10 with `lim1 = 4`, then INC ch1 -> `idx1` = 0 and `wrap[1]` pulses.
- With `IDX_STEP_EN`, N=3, limits 1,1,1:
  - 8× STEP -> `idx_flat` counts 000…111 in binary order.
  - The 8th STEP returns all channels to 0, pulses `wrap` = 3'b111 and sets `done`.
  - CLEAR_ALL then clears `done`.
- Illegal ops:
  - INC with `op_sel = 3` (N=3) -> no index change and `err` pulses for 1 cycle.
  - Opcode 7 -> same response.
  - `rd_sel = 3` -> `rd_data` reads 0.
- Build without `IDX_STEP_EN`: a STEP op -> no index change, `err` pulse, and `done` stays 0.
